hex_scroll_ctrl: RTL and testbench



---
 rtl/hex_scroll_ctrl_pkg.sv | 25 ++
 rtl/hex_scroll_ctrl_if.sv | 33 +++
 rtl/hex_seg_decode.sv | 17 +
 rtl/hex_scroll_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_hex_scroll_ctrl.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hex_scroll_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hex_scroll_ctrl_pkg
// Shared definitions for the HEX scroll/blink sequencer:
//   - FSM state encoding (IDLE / SHOW / SCROLL)
//   - blank pattern for an active-low seven-segment digit
//   - the 16-entry active-low segment code table (bit 6 = g ... bit 0 = a)
// ---------------------------------------------------------------------------
package hex_scroll_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t SHOW   = 2'd1;
    localparam state_t SCROLL = 2'd2;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_CODE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex_scroll_ctrl_if.sv
// ---------------------------------------------------------------------------
// hex_scroll_ctrl_if
// Control and display bundle between the top-level control logic (master)
// and the scroll sequencer (slave).
//   load, load_data      : message capture pulse and message nibbles
//   run, dir, blink_en   : scroll enable, scroll direction, blink enable
//   clear                : return-to-idle pulse
//   seg_out              : active-low segment patterns, 7 bits per digit
//   wrap                 : one-cycle pulse when the window position wraps
// ---------------------------------------------------------------------------
interface hex_scroll_ctrl_if #(
    parameter int MSG_LEN    = 16,
    parameter int NUM_DIGITS = 6
);
    logic                    load;
    logic [4*MSG_LEN-1:0]    load_data;
    logic                    run;
    logic                    dir;
    logic                    blink_en;
    logic                    clear;
    logic [7*NUM_DIGITS-1:0] seg_out;
    logic                    wrap;

    modport master (
        output load, load_data, run, dir, blink_en, clear,
        input  seg_out, wrap
    );

    modport slave (
        input  load, load_data, run, dir, blink_en, clear,
        output seg_out, wrap
    );
endinterface

// File: rtl/hex_seg_decode.sv
// ---------------------------------------------------------------------------
// hex_seg_decode
// Purely combinational nibble -> active-low seven-segment decoder.
//   nibble : 4-bit hex value
//   seg    : active-low segments, bit 6 = g ... bit 0 = a
// ---------------------------------------------------------------------------
module hex_seg_decode
    import hex_scroll_ctrl_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Every 4-bit value has a table entry, so no fallback is needed.
    assign seg = SEG_CODE[nibble];

endmodule

// File: rtl/hex_scroll_ctrl.sv
// ---------------------------------------------------------------------------
// hex_scroll_ctrl
// Scroll/blink sequencer for the six seven-segment displays HEX5..HEX0.
// Holds a nibble message, selects a sliding NUM_DIGITS-wide window into it,
// steps the window once per prescaled tick and drives registered,
// active-low segment patterns.
//   clk    : system clock
//   reset  : asynchronous, active-high reset
//   bus    : hex_scroll_ctrl_if.slave (load/load_data/run/dir/blink_en/clear
//            in, seg_out/wrap out)
// Timing: msg/pos/state update on the edge after the input cycle; seg_out
// follows one edge later.
// ---------------------------------------------------------------------------
module hex_scroll_ctrl
    import hex_scroll_ctrl_pkg::*;
#(
    parameter int TICK_DIV   = 25000000,
    parameter int MSG_LEN    = 16,
    parameter int NUM_DIGITS = 6
)(
    input  logic             clk,
    input  logic             reset,
    hex_scroll_ctrl_if.slave bus
);

    localparam int PW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int CW = $clog2(TICK_DIV);
    localparam int XW = PW + 4;

    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [PW-1:0] POS_LAST = PW'(MSG_LEN - 1);
    localparam logic [XW-1:0] LEN_X    = XW'(MSG_LEN);

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [4*MSG_LEN-1:0]    msg_r;
    logic [PW-1:0]           pos_r;
    logic [CW-1:0]           presc_r;
    logic                    blink_r;
    logic                    wrap_r;
    logic [7*NUM_DIGITS-1:0] seg_r;

    logic                    cnt_last_s;
    logic                    tick_s;
    logic                    step_s;
    logic                    presc_hold_s;
    logic                    blank_s;
    logic [PW-1:0]           pos_step_s;
    logic                    wrap_step_s;
    logic [7*NUM_DIGITS-1:0] window_s;
    logic [3:0]              msg_nib_s [MSG_LEN];

    // (base + offs) mod MSG_LEN by repeated compare-and-subtract; offs never
    // exceeds NUM_DIGITS-1, so NUM_DIGITS passes cover even MSG_LEN = 1.
    function automatic logic [PW-1:0] wrap_index(input logic [PW-1:0] base,
                                                 input int unsigned offs);
        logic [XW-1:0] v;
        v = {4'b0000, base} + XW'(offs);
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (v >= LEN_X) begin
                v = v - LEN_X;
            end else begin
                v = v;
            end
        end
        return v[PW-1:0];
    endfunction

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: clear beats load beats run. IDLE can also be left with
    // run, so a cleared message can be shown again without reloading it.
    always_comb begin
        state_nxt_s = state_r;
        if (bus.clear) begin
            state_nxt_s = IDLE;
        end else if (bus.load) begin
            state_nxt_s = bus.run ? SCROLL : SHOW;
        end else begin
            case (state_r)
                IDLE:    state_nxt_s = bus.run ? SCROLL : IDLE;
                SHOW:    state_nxt_s = bus.run ? SCROLL : SHOW;
                SCROLL:  state_nxt_s = bus.run ? SCROLL : SHOW;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    assign cnt_last_s = (presc_r == CNT_LAST);

    // FSM outputs: tick qualification, step enable, prescaler hold, blanking.
    always_comb begin
        tick_s       = 1'b0;
        step_s       = 1'b0;
        presc_hold_s = 1'b1;
        blank_s      = 1'b1;
        case (state_r)
            IDLE: begin
                tick_s       = 1'b0;
                presc_hold_s = 1'b1;
                blank_s      = 1'b1;
            end
            SHOW: begin
                tick_s       = cnt_last_s;
                presc_hold_s = 1'b0;
                blank_s      = 1'b0;
            end
            SCROLL: begin
                tick_s       = cnt_last_s;
                step_s       = cnt_last_s & bus.run;
                // Leaving SCROLL restarts the tick period.
                presc_hold_s = ~bus.run;
                blank_s      = 1'b0;
            end
            default: begin
                tick_s       = 1'b0;
                presc_hold_s = 1'b1;
                blank_s      = 1'b1;
            end
        endcase
    end

    // Next window position for one step and whether that step wraps.
    always_comb begin
        pos_step_s  = pos_r;
        wrap_step_s = 1'b0;
        if (bus.dir == 1'b0) begin
            if (pos_r == POS_LAST) begin
                pos_step_s  = '0;
                wrap_step_s = 1'b1;
            end else begin
                pos_step_s  = pos_r + PW'(1);
                wrap_step_s = 1'b0;
            end
        end else begin
            if (pos_r == '0) begin
                pos_step_s  = POS_LAST;
                wrap_step_s = 1'b1;
            end else begin
                pos_step_s  = pos_r - PW'(1);
                wrap_step_s = 1'b0;
            end
        end
    end

    // Message, position, prescaler, blink phase and wrap pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            msg_r   <= '0;
            pos_r   <= '0;
            presc_r <= '0;
            blink_r <= 1'b0;
            wrap_r  <= 1'b0;
        end else if (bus.clear) begin
            // Message and position are kept across a clear.
            presc_r <= '0;
            blink_r <= 1'b0;
            wrap_r  <= 1'b0;
        end else if (bus.load) begin
            // A load coincident with a tick suppresses the step and wrap.
            msg_r   <= bus.load_data;
            pos_r   <= '0;
            presc_r <= '0;
            blink_r <= 1'b0;
            wrap_r  <= 1'b0;
        end else begin
            if (presc_hold_s || tick_s) begin
                presc_r <= '0;
            end else begin
                presc_r <= presc_r + CW'(1);
            end
            if (step_s) begin
                pos_r  <= pos_step_s;
                wrap_r <= wrap_step_s;
            end else begin
                wrap_r <= 1'b0;
            end
            if (!bus.blink_en) begin
                blink_r <= 1'b0;
            end else if (tick_s) begin
                blink_r <= ~blink_r;
            end else begin
                blink_r <= blink_r;
            end
        end
    end

    // HEX(NUM_DIGITS-1-j) shows message nibble (pos+j) mod MSG_LEN.
    for (genvar k = 0; k < MSG_LEN; k++) begin : g_nib
        assign msg_nib_s[k] = msg_r[4*k +: 4];
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        logic [PW-1:0] idx_s;
        logic [6:0]    code_s;

        assign idx_s = wrap_index(pos_r, NUM_DIGITS - 1 - i);

        hex_seg_decode u_dec (
            .nibble (msg_nib_s[idx_s]),
            .seg    (code_s)
        );

        assign window_s[7*i +: 7] = code_s;
    end

    // Registered segment outputs; blank in IDLE and during the blink phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_r <= {NUM_DIGITS{SEG_BLANK}};
        end else if (blank_s || blink_r) begin
            seg_r <= {NUM_DIGITS{SEG_BLANK}};
        end else begin
            seg_r <= window_s;
        end
    end

    assign bus.seg_out = seg_r;
    assign bus.wrap    = wrap_r;

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hex_scroll_ctrl
// Self-checking bench for hex_scroll_ctrl with TICK_DIV=4, MSG_LEN=8.
// A behavioural model (message as an array of nibbles, position and tick
// counter as integers, modulo arithmetic) predicts seg_out and wrap every
// cycle; a vector table plus hand sequences pin down the directed cases.
// ---------------------------------------------------------------------------
module tb_hex_scroll_ctrl;

    localparam int TD = 4;
    localparam int ML = 8;
    localparam int ND = 6;

    localparam int M_IDLE   = 0;
    localparam int M_SHOW   = 1;
    localparam int M_SCROLL = 2;

    localparam bit [31:0] MSG_A = 32'h76543210;
    localparam bit [31:0] MSG_B = 32'hFEDCBA98;

    localparam bit [6:0] CODE_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic clk = 1'b0;
    logic reset;

    hex_scroll_ctrl_if #(.MSG_LEN(ML), .NUM_DIGITS(ND)) bus ();

    hex_scroll_ctrl #(.TICK_DIV(TD), .MSG_LEN(ML), .NUM_DIGITS(ND)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    int      m_mode;
    int      m_pos;
    int      m_cnt;
    bit      m_ph;
    int      m_msg [ML];
    bit [41:0] m_seg;
    bit      m_wrap;

    typedef struct {
        bit        ld;
        bit [31:0] data;
        bit        clr;
        bit        run;
        bit        dir;
        bit        blk;
        int        reps;
        bit        chk;
        bit [6:0]  h5;
        bit [6:0]  h4;
        bit [6:0]  h0;
        bit        wr;
    } vec_t;

    vec_t vt [$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, exp);
        end
    endtask

    function automatic bit [41:0] model_view();
        bit [41:0] v;
        v = '1;
        if (m_mode != M_IDLE && !m_ph) begin
            for (int j = 0; j < ND; j++) begin
                v[7*(ND-1-j) +: 7] = CODE_TAB[m_msg[(m_pos + j) % ML]];
            end
        end
        return v;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_pos  = 0;
        m_cnt  = 0;
        m_ph   = 1'b0;
        for (int k = 0; k < ML; k++) m_msg[k] = 0;
        m_seg  = '1;
        m_wrap = 1'b0;
    endtask

    task automatic model_edge(input bit ld, input bit [31:0] data, input bit clr,
                              input bit run, input bit dir, input bit blk);
        bit tick;
        m_seg  = model_view();
        m_wrap = 1'b0;
        tick   = (m_mode != M_IDLE) && (m_cnt == TD - 1);
        if (clr) begin
            m_mode = M_IDLE;
            m_cnt  = 0;
            m_ph   = 1'b0;
        end else if (ld) begin
            for (int k = 0; k < ML; k++) m_msg[k] = int'(data[4*k +: 4]);
            m_pos  = 0;
            m_cnt  = 0;
            m_ph   = 1'b0;
            m_mode = run ? M_SCROLL : M_SHOW;
        end else if (m_mode == M_IDLE) begin
            m_cnt = 0;
            m_ph  = blk ? m_ph : 1'b0;
            if (run) m_mode = M_SCROLL;
        end else begin
            if (tick && m_mode == M_SCROLL && run) begin
                if (!dir) begin
                    m_wrap = (m_pos == ML - 1);
                    m_pos  = (m_pos + 1) % ML;
                end else begin
                    m_wrap = (m_pos == 0);
                    m_pos  = (m_pos + ML - 1) % ML;
                end
            end
            m_ph = blk ? (tick ? !m_ph : m_ph) : 1'b0;
            if (m_mode == M_SCROLL && !run) begin
                m_cnt  = 0;
                m_mode = M_SHOW;
            end else begin
                m_cnt = (m_cnt + 1) % TD;
                if (run) m_mode = M_SCROLL;
            end
        end
    endtask

    task automatic step(input bit ld, input bit [31:0] data, input bit clr,
                        input bit run, input bit dir, input bit blk);
        bus.load      = ld;
        bus.load_data = data;
        bus.clear     = clr;
        bus.run       = run;
        bus.dir       = dir;
        bus.blink_en  = blk;
        @(posedge clk);
        model_edge(ld, data, clr, run, dir, blk);
        #1;
        check("model seg_out", 64'(bus.seg_out), 64'(m_seg));
        check("model wrap", 64'(bus.wrap), 64'(m_wrap));
    endtask

    function automatic vec_t mk(bit ld, bit [31:0] d, bit clr, bit run, bit dir, bit blk,
                                int reps, bit chk, bit [6:0] h5, bit [6:0] h4,
                                bit [6:0] h0, bit wr);
        vec_t v;
        v.ld = ld; v.data = d; v.clr = clr; v.run = run; v.dir = dir; v.blk = blk;
        v.reps = reps; v.chk = chk; v.h5 = h5; v.h4 = h4; v.h0 = h0; v.wr = wr;
        return v;
    endfunction

    initial begin
        bit rdir;
        bit rblk;

        reset         = 1'b1;
        bus.load      = 1'b0;
        bus.load_data = '0;
        bus.clear     = 1'b0;
        bus.run       = 1'b0;
        bus.dir       = 1'b0;
        bus.blink_en  = 1'b0;
        model_reset();

        // Static load: blank first, then the window at pos 0 for 20 cycles.
        vt.push_back(mk(1, MSG_A, 0, 0, 0, 0,  1, 1, 7'h7F, 7'h7F, 7'h7F, 0));
        vt.push_back(mk(0, MSG_A, 0, 0, 0, 0,  1, 1, 7'h40, 7'h79, 7'h12, 0));
        vt.push_back(mk(0, MSG_A, 0, 0, 0, 0, 20, 1, 7'h40, 7'h79, 7'h12, 0));
        // Scroll left: first step, then full lap with wrap pulse.
        vt.push_back(mk(1, MSG_A, 0, 1, 0, 0,  1, 0, 7'h00, 7'h00, 7'h00, 0));
        vt.push_back(mk(0, MSG_A, 0, 1, 0, 0,  5, 1, 7'h79, 7'h24, 7'h02, 0));
        vt.push_back(mk(0, MSG_A, 0, 1, 0, 0, 27, 1, 7'h78, 7'h40, 7'h19, 1));
        vt.push_back(mk(0, MSG_A, 0, 1, 0, 0,  1, 1, 7'h40, 7'h79, 7'h12, 0));
        // Scroll right: first tick wraps 0 -> 7.
        vt.push_back(mk(1, MSG_A, 0, 1, 1, 0,  1, 0, 7'h00, 7'h00, 7'h00, 0));
        vt.push_back(mk(0, MSG_A, 0, 1, 1, 0,  4, 1, 7'h40, 7'h79, 7'h12, 1));
        vt.push_back(mk(0, MSG_A, 0, 1, 1, 0,  1, 1, 7'h78, 7'h40, 7'h19, 0));
        // Blink in SHOW, then release blink.
        vt.push_back(mk(1, MSG_A, 0, 0, 0, 1,  1, 0, 7'h00, 7'h00, 7'h00, 0));
        vt.push_back(mk(0, MSG_A, 0, 0, 0, 1,  4, 1, 7'h40, 7'h79, 7'h12, 0));
        vt.push_back(mk(0, MSG_A, 0, 0, 0, 1,  1, 1, 7'h7F, 7'h7F, 7'h7F, 0));
        vt.push_back(mk(0, MSG_A, 0, 0, 0, 1,  4, 1, 7'h40, 7'h79, 7'h12, 0));
        vt.push_back(mk(0, MSG_A, 0, 0, 0, 1,  4, 1, 7'h7F, 7'h7F, 7'h7F, 0));
        vt.push_back(mk(0, MSG_A, 0, 0, 0, 0,  1, 1, 7'h7F, 7'h7F, 7'h7F, 0));
        vt.push_back(mk(0, MSG_A, 0, 0, 0, 0,  1, 1, 7'h40, 7'h79, 7'h12, 0));
        // Load coincident with a tick: new message at pos 0, no wrap.
        vt.push_back(mk(1, MSG_A, 0, 1, 0, 0,  1, 0, 7'h00, 7'h00, 7'h00, 0));
        vt.push_back(mk(0, MSG_A, 0, 1, 0, 0,  3, 0, 7'h00, 7'h00, 7'h00, 0));
        vt.push_back(mk(1, MSG_B, 0, 1, 0, 0,  1, 1, 7'h40, 7'h79, 7'h12, 0));
        vt.push_back(mk(0, MSG_B, 0, 1, 0, 0,  1, 1, 7'h00, 7'h10, 7'h21, 0));
        // Clear (with a competing load) in SCROLL at pos 1, then rerun.
        vt.push_back(mk(1, MSG_A, 0, 1, 0, 0,  1, 0, 7'h00, 7'h00, 7'h00, 0));
        vt.push_back(mk(0, MSG_A, 0, 1, 0, 0,  5, 0, 7'h00, 7'h00, 7'h00, 0));
        vt.push_back(mk(1, MSG_B, 1, 1, 0, 0,  1, 0, 7'h00, 7'h00, 7'h00, 0));
        vt.push_back(mk(0, MSG_B, 0, 0, 0, 0,  1, 1, 7'h7F, 7'h7F, 7'h7F, 0));
        vt.push_back(mk(0, MSG_B, 0, 0, 0, 0,  3, 1, 7'h7F, 7'h7F, 7'h7F, 0));
        vt.push_back(mk(0, MSG_B, 0, 1, 0, 0,  1, 0, 7'h00, 7'h00, 7'h00, 0));
        vt.push_back(mk(0, MSG_B, 0, 1, 0, 0,  1, 1, 7'h79, 7'h24, 7'h02, 0));

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("reset seg_out", 64'(bus.seg_out), 64'({ND{7'h7F}}));
        check("reset wrap", 64'(bus.wrap), 64'(1'b0));
        reset = 1'b0;

        // Directed vector table.
        foreach (vt[i]) begin
            for (int r = 0; r < vt[i].reps; r++) begin
                step(vt[i].ld, vt[i].data, vt[i].clr, vt[i].run, vt[i].dir, vt[i].blk);
            end
            if (vt[i].chk) begin
                check($sformatf("vec%0d hex5/hex4/hex0/wrap", i),
                      64'({bus.seg_out[41:35], bus.seg_out[34:28], bus.seg_out[6:0], bus.wrap}),
                      64'({vt[i].h5, vt[i].h4, vt[i].h0, vt[i].wr}));
            end
        end

        // Reset asserted between clock edges in the middle of a scroll.
        step(1, MSG_A, 0, 1, 0, 0);
        repeat (10) step(0, MSG_A, 0, 1, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        check("async reset seg_out", 64'(bus.seg_out), 64'({ND{7'h7F}}));
        check("async reset wrap", 64'(bus.wrap), 64'(1'b0));
        model_reset();
        @(posedge clk);
        #1;
        check("held reset seg_out", 64'(bus.seg_out), 64'({ND{7'h7F}}));
        reset = 1'b0;
        repeat (3) step(0, MSG_A, 0, 0, 0, 0);
        check("idle after reset", 64'(bus.seg_out), 64'({ND{7'h7F}}));
        repeat (2) step(0, MSG_A, 0, 1, 0, 0);
        check("message lost by reset", 64'(bus.seg_out), 64'({ND{7'h40}}));

        // Randomized traffic against the model.
        rdir = 1'b0;
        rblk = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 31) == 0) rdir = ~rdir;
            if ($urandom_range(0, 47) == 0) rblk = ~rblk;
            step($urandom_range(0, 39) == 0, $urandom, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 9) != 0, rdir, rblk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
